// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_e;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF/DM) and memory-side bus of the memory port arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic              IF_REQ;
   logic [ADDR_W-1:0] IF_ADDR;
   logic              IF_ACK;
   logic [DATA_W-1:0] IF_RDATA;

   logic              DM_REQ;
   logic              DM_WE;
   logic [ADDR_W-1:0] DM_ADDR;
   logic [DATA_W-1:0] DM_WDATA;
   logic              DM_ACK;
   logic [DATA_W-1:0] DM_RDATA;

   logic              MEM_EN;
   logic              MEM_WE;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [DATA_W-1:0] MEM_WDATA;
   logic [DATA_W-1:0] MEM_RDATA;

   modport slave (
      input  IF_REQ, IF_ADDR, DM_REQ, DM_WE, DM_ADDR, DM_WDATA, MEM_RDATA,
      output IF_ACK, IF_RDATA, DM_ACK, DM_RDATA, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
   );

   modport master (
      output IF_REQ, IF_ADDR, DM_REQ, DM_WE, DM_ADDR, DM_WDATA, MEM_RDATA,
      input  IF_ACK, IF_RDATA, DM_ACK, DM_RDATA, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (IF, read-only) and memory stage (DM).
// Fixed-latency sequencing: IDLE -> ISSUE -> (WAIT x MEM_LAT) -> IDLE; all outputs registered.
// Optional MEM_ARB_FAIR_EN: starvation counter forces an IF grant after STARVE_MAX DM grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic ENABLE,
   input  logic FLUSH,
   output logic BUSY,
   mem_port_arbiter_if.slave bus
);

   localparam logic [3:0] LatCnt = 4'(MEM_LAT);

   if (MEM_LAT == 0 || MEM_LAT > 15 || STARVE_MAX == 0) begin : g_bad_param
      $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX nonzero");
   end

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              drop_q, drop_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              if_ack_q, if_ack_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              dm_ack_q, dm_ack_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              busy_q, busy_d;

   logic grant_if, grant_dm, last_wait, done, drop_now;

`ifdef MEM_ARB_FAIR_EN
   localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
   logic [StarveW-1:0] starve_q, starve_d;
`endif

   // State register plus all registered outputs
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IF;
         cnt_q       <= '0;
         drop_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_ack_q    <= 1'b0;
         dm_rdata_q  <= '0;
         busy_q      <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
         starve_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         drop_q      <= drop_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_ack_q    <= dm_ack_d;
         dm_rdata_q  <= dm_rdata_d;
         busy_q      <= busy_d;
`ifdef MEM_ARB_FAIR_EN
         starve_q    <= starve_d;
`endif
      end
   end

   // Arbitration and next-state: grants only from IDLE, in-flight work ignores ENABLE
   always_comb begin
      logic if_cand;
      logic dm_cand;
      if_cand   = bus.IF_REQ & ~FLUSH;
      dm_cand   = bus.DM_REQ;
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      last_wait = (state_q == ST_WAIT) && (cnt_q == 4'd1);
      state_d   = state_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      drop_d    = drop_q;

      if (state_q == ST_IDLE && ENABLE) begin
`ifdef MEM_ARB_FAIR_EN
         // At the starvation limit IF overrides DM priority
         if (if_cand && dm_cand && starve_q == StarveW'(STARVE_MAX)) begin
            grant_if = 1'b1;
         end else begin
            grant_dm = dm_cand;
            grant_if = if_cand & ~dm_cand;
         end
`else
         grant_dm = dm_cand;
         grant_if = if_cand & ~dm_cand;
`endif
      end

`ifdef MEM_ARB_FAIR_EN
      starve_d = starve_q;
      if (grant_if) begin
         starve_d = '0;
      end else if (grant_dm) begin
         if (!bus.IF_REQ) begin
            starve_d = '0;
         end else if (starve_q != StarveW'(STARVE_MAX)) begin
            starve_d = starve_q + StarveW'(1);
         end
      end
`endif

      if (grant_dm) begin
         owner_d = OWN_DM;
      end else if (grant_if) begin
         owner_d = OWN_IF;
      end

      unique case (state_q)
         ST_IDLE: begin
            drop_d = 1'b0;
            if (grant_if || grant_dm) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            drop_d = drop_q | (FLUSH & (owner_q == OWN_IF));
            if (mem_we_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = LatCnt;
            end
         end
         ST_WAIT: begin
            drop_d = drop_q | (FLUSH & (owner_q == OWN_IF));
            cnt_d  = cnt_q - 4'd1;
            if (last_wait) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      // A flush in the final WAIT cycle must still suppress delivery
      drop_now    = drop_q | (FLUSH & (owner_q == OWN_IF));
      done        = ((state_q == ST_ISSUE) && mem_we_q) || last_wait;
      mem_en_d    = grant_if | grant_dm;
      mem_we_d    = grant_dm & bus.DM_WE;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (grant_dm) begin
         mem_addr_d  = bus.DM_ADDR;
         mem_wdata_d = bus.DM_WDATA;
      end else if (grant_if) begin
         mem_addr_d  = bus.IF_ADDR;
      end
      if_ack_d   = done && (owner_q == OWN_IF) && !drop_now;
      dm_ack_d   = done && (owner_q == OWN_DM);
      if_rdata_d = (last_wait && owner_q == OWN_IF && !drop_now) ? bus.MEM_RDATA : if_rdata_q;
      dm_rdata_d = (last_wait && owner_q == OWN_DM) ? bus.MEM_RDATA : dm_rdata_q;
      busy_d     = (state_d != ST_IDLE);
   end

   assign BUSY          = busy_q;
   assign bus.MEM_EN    = mem_en_q;
   assign bus.MEM_WE    = mem_we_q;
   assign bus.MEM_ADDR  = mem_addr_q;
   assign bus.MEM_WDATA = mem_wdata_q;
   assign bus.IF_ACK    = if_ack_q;
   assign bus.IF_RDATA  = if_rdata_q;
   assign bus.DM_ACK    = dm_ack_q;
   assign bus.DM_RDATA  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2).
// Memory model returns rom(addr) exactly two cycles after MEM_EN, garbage otherwise.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic CLOCK = 1'b0;
   logic RESET;
   logic ENABLE;
   logic FLUSH;
   logic BUSY;

   int n_cmp = 0;
   int n_err = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .MEM_LAT(2),
      .STARVE_MAX(2)
   ) dut (
      .CLOCK(CLOCK),
      .RESET(RESET),
      .ENABLE(ENABLE),
      .FLUSH(FLUSH),
      .BUSY(BUSY),
      .bus(bus)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h40:  rom = 32'h2402000A;
         32'h200: rom = 32'h13579BDF;
         default: rom = a ^ 32'hA5A50000;
      endcase
   endfunction

   // Two-stage read pipeline: data appears in the cycle MEM_EN+2
   logic [1:0]  rd_v = 2'b00;
   logic [31:0] rd_a0 = '0;
   logic [31:0] rd_a1 = '0;
   always @(posedge CLOCK) begin
      rd_v  <= {rd_v[0], bus.MEM_EN & ~bus.MEM_WE};
      rd_a0 <= bus.MEM_ADDR;
      rd_a1 <= rd_a0;
   end
   assign bus.MEM_RDATA = rd_v[1] ? rom(rd_a1) : 32'hBAD0BAD0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      int          grants;
      int          if_acks;
      int          need;
      logic [9:0]  order;
      logic [9:0]  exp_order;

      RESET = 1'b1; ENABLE = 1'b1; FLUSH = 1'b0;
      bus.IF_REQ = 1'b0; bus.IF_ADDR = '0;
      bus.DM_REQ = 1'b0; bus.DM_WE = 1'b0; bus.DM_ADDR = '0; bus.DM_WDATA = '0;
      tick(); tick();
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_mem_en", 32'(bus.MEM_EN), 32'd0);
      check("rst_if_rdata", bus.IF_RDATA, 32'd0);
      check("rst_dm_ack", 32'(bus.DM_ACK), 32'd0);
      RESET = 1'b0;
      tick();

      // 1: single IF read
      bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h40;
      tick();
      check("t1_c1_mem_en", 32'(bus.MEM_EN), 32'd1);
      check("t1_c1_addr", bus.MEM_ADDR, 32'h40);
      check("t1_c1_busy", 32'(BUSY), 32'd1);
      tick();
      check("t1_c2_mem_en", 32'(bus.MEM_EN), 32'd0);
      tick();
      check("t1_c3_busy", 32'(BUSY), 32'd1);
      check("t1_c3_ack", 32'(bus.IF_ACK), 32'd0);
      tick();
      check("t1_c4_ack", 32'(bus.IF_ACK), 32'd1);
      check("t1_c4_rdata", bus.IF_RDATA, 32'h2402000A);
      check("t1_c4_busy", 32'(BUSY), 32'd0);
      bus.IF_REQ = 1'b0;
      tick();
      check("t1_c5_ack", 32'(bus.IF_ACK), 32'd0);
      check("t1_c5_rdata_hold", bus.IF_RDATA, 32'h2402000A);

      // 2: DM write beats simultaneous IF read
      bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h80;
      bus.DM_REQ = 1'b1; bus.DM_WE = 1'b1; bus.DM_ADDR = 32'h100; bus.DM_WDATA = 32'hDEADBEEF;
      tick();
      check("t2_c1_mem_en", 32'(bus.MEM_EN), 32'd1);
      check("t2_c1_mem_we", 32'(bus.MEM_WE), 32'd1);
      check("t2_c1_addr", bus.MEM_ADDR, 32'h100);
      check("t2_c1_wdata", bus.MEM_WDATA, 32'hDEADBEEF);
      tick();
      check("t2_c2_dm_ack", 32'(bus.DM_ACK), 32'd1);
      check("t2_c2_mem_en", 32'(bus.MEM_EN), 32'd0);
      bus.DM_REQ = 1'b0; bus.DM_WE = 1'b0;
      tick();
      check("t2_c3_dm_ack", 32'(bus.DM_ACK), 32'd0);
      check("t2_c3_mem_en", 32'(bus.MEM_EN), 32'd1);
      check("t2_c3_addr", bus.MEM_ADDR, 32'h80);
      check("t2_c3_mem_we", 32'(bus.MEM_WE), 32'd0);
      tick(); tick();
      check("t2_c5_if_ack", 32'(bus.IF_ACK), 32'd0);
      tick();
      check("t2_c6_if_ack", 32'(bus.IF_ACK), 32'd1);
      check("t2_c6_rdata", bus.IF_RDATA, 32'hA5A50080);
      bus.IF_REQ = 1'b0;
      tick();

      // 3: flush during IF WAIT drops delivery; DM read afterwards is unaffected
      bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h40;
      tick();
      tick();
      FLUSH = 1'b1; bus.IF_REQ = 1'b0;
      tick();
      FLUSH = 1'b0;
      check("t3_c3_if_ack", 32'(bus.IF_ACK), 32'd0);
      tick();
      check("t3_c4_if_ack", 32'(bus.IF_ACK), 32'd0);
      check("t3_c4_rdata_kept", bus.IF_RDATA, 32'hA5A50080);
      check("t3_c4_busy", 32'(BUSY), 32'd0);
      bus.DM_REQ = 1'b1; bus.DM_WE = 1'b0; bus.DM_ADDR = 32'h200;
      tick();
      check("t3_c5_mem_en", 32'(bus.MEM_EN), 32'd1);
      check("t3_c5_addr", bus.MEM_ADDR, 32'h200);
      tick(); tick(); tick();
      check("t3_c8_dm_ack", 32'(bus.DM_ACK), 32'd1);
      check("t3_c8_dm_rdata", bus.DM_RDATA, 32'h13579BDF);
      check("t3_c8_if_rdata", bus.IF_RDATA, 32'hA5A50080);
      bus.DM_REQ = 1'b0;
      tick();

      // 4: reset mid-read clears every output; re-request completes
      bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h40;
      tick();
      tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("t4_c3_busy", 32'(BUSY), 32'd0);
      check("t4_c3_if_ack", 32'(bus.IF_ACK), 32'd0);
      check("t4_c3_if_rdata", bus.IF_RDATA, 32'd0);
      check("t4_c3_dm_rdata", bus.DM_RDATA, 32'd0);
      check("t4_c3_mem_addr", bus.MEM_ADDR, 32'd0);
      check("t4_c3_mem_wdata", bus.MEM_WDATA, 32'd0);
      check("t4_c3_mem_en", 32'(bus.MEM_EN), 32'd0);
      tick();
      check("t4_c4_if_ack", 32'(bus.IF_ACK), 32'd0);
      check("t4_c4_mem_en", 32'(bus.MEM_EN), 32'd1);
      tick(); tick(); tick();
      check("t4_c7_if_ack", 32'(bus.IF_ACK), 32'd1);
      check("t4_c7_rdata", bus.IF_RDATA, 32'h2402000A);
      bus.IF_REQ = 1'b0;
      tick();

      // 5: ENABLE low blocks grants but never stalls an in-flight read
      ENABLE = 1'b0; bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h44;
      for (int c = 1; c <= 5; c++) begin
         tick();
         check($sformatf("t5_c%0d_mem_en", c), 32'(bus.MEM_EN), 32'd0);
      end
      ENABLE = 1'b1;
      tick();
      check("t5_c6_mem_en", 32'(bus.MEM_EN), 32'd1);
      check("t5_c6_addr", bus.MEM_ADDR, 32'h44);
      ENABLE = 1'b0;
      tick(); tick(); tick();
      check("t5_c9_if_ack", 32'(bus.IF_ACK), 32'd1);
      check("t5_c9_rdata", bus.IF_RDATA, 32'hA5A50044);
      bus.IF_REQ = 1'b0; ENABLE = 1'b1;
      tick();

      // 6: both requesters hold reads continuously; record grant order (bit=1 means DM)
`ifdef MEM_ARB_FAIR_EN
      need = 6;
      exp_order = 10'b0000011011;
`else
      need = 10;
      exp_order = 10'b1111111111;
`endif
      grants = 0; if_acks = 0; order = '0;
      bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h48;
      bus.DM_REQ = 1'b1; bus.DM_WE = 1'b0; bus.DM_ADDR = 32'h300;
      for (int c = 0; c < 80 && grants < need; c++) begin
         tick();
         if (bus.MEM_EN) begin
            order[grants] = (bus.MEM_ADDR == 32'h300);
            grants++;
         end
         if (bus.IF_ACK) if_acks++;
      end
      check("t6_grant_count", 32'(grants), 32'(need));
      check("t6_grant_order", {22'd0, order}, {22'd0, exp_order});
`ifdef MEM_ARB_FAIR_EN
      check("t6_if_acks", 32'(if_acks), 32'd1);
`else
      check("t6_if_acks", 32'(if_acks), 32'd0);
`endif
      check("t6_dm_rdata", bus.DM_RDATA, 32'hA5A50300);
      bus.IF_REQ = 1'b0; bus.DM_REQ = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      check("t6_idle_busy", 32'(BUSY), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch stage (read-only requester IF) and the memory stage (read/write requester DM).
- Sequences each memory transaction: fixed read latency, registered response, one-cycle ACK.
- Supplies a BUSY indication that the hazard unit ORs into the pipeline STALL, and drops in-flight fetch results when a branch flush arrives.

Parameters:
ADDR_W, 32, address width (byte address, passed through unchanged)
DATA_W, 32, data width
MEM_LAT, 2, memory read latency in cycles after MEM_EN; legal range 1..15
STARVE_MAX, 4, consecutive DM grants while IF waits before IF is forced; used only with the fairness feature

Ports:
CLOCK  in  1  single clock, rising edge
RESET  in  1  synchronous, active-high
ENABLE  in  1  global enable; low blocks new grants
FLUSH  in  1  branch-taken flush; cancels fetch delivery
IF_REQ  in  1  fetch request, held until IF_ACK
IF_ADDR  in  ADDR_W  fetch address, stable while IF_REQ
IF_ACK  out  1  one-cycle read-complete pulse
IF_RDATA  out  DATA_W  fetch data, valid with IF_ACK
DM_REQ  in  1  data request, held until DM_ACK
DM_WE  in  1  1 = write, 0 = read
DM_ADDR  in  ADDR_W  data address
DM_WDATA  in  DATA_W  write data
DM_ACK  out  1  one-cycle completion pulse
DM_RDATA  out  DATA_W  read data, valid with DM_ACK on reads
MEM_EN  out  1  memory access strobe, one cycle per transaction
MEM_WE  out  1  memory write enable, qualifies MEM_EN
MEM_ADDR  out  ADDR_W  memory address
MEM_WDATA  out  DATA_W  memory write data
MEM_RDATA  in  DATA_W  memory read data, valid MEM_LAT cycles after MEM_EN
BUSY  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, with a latched owner (IF/DM). All outputs are registered.
- IDLE arbitration (ENABLE=1):
  - DM_REQ wins over IF_REQ.
  - IF_REQ is ignored in any cycle where FLUSH=1.
  - Winner's addr/we/wdata are latched, then go to ISSUE.
  - If ENABLE=0 or there is no request, stay in IDLE.
- ISSUE (cycle 1 after grant):
  - MEM_EN=1; MEM_WE/ADDR/WDATA carry the latched values.
  - A write goes to IDLE, and the owner ACK is high in the next cycle (cycle 2).
  - A read loads a counter with MEM_LAT and goes to WAIT.
- WAIT: lasts exactly MEM_LAT cycles. In the last WAIT cycle MEM_RDATA is captured into the owner RDATA register, then go to IDLE with ACK high. Read ACK is at cycle MEM_LAT+2 after the request is sampled.
- ACK cycle is an IDLE cycle:
  - A REQ still high in the ACK cycle counts as a new request (back-to-back allowed).
  - Requesters wanting no further access drop REQ in the ACK cycle.
- RDATA outputs hold their value until the next capture. ACK pulses are exactly one cycle.
- MEM_EN/MEM_WE are 0 outside ISSUE. MEM_ADDR/MEM_WDATA hold their last value.
- ENABLE=0 never stalls an in-flight transaction: fixed memory latency must be honoured.
- FLUSH:
  - If the owner is IF and FLUSH=1 in any cycle from ISSUE through the last WAIT cycle, a drop flag is set.
  - The memory timing still completes, but IF_ACK stays 0 and IF_RDATA is not updated.
  - The drop flag clears on return to IDLE. FLUSH never affects DM transactions.
- Reset (any state, including mid-WAIT): next cycle state=IDLE and owner, counters and drop flag are cleared. Every output is 0, including RDATA registers, so the in-flight ACK is lost. The requester must re-request.
- The counter is 4 bits wide. MEM_LAT=1 gives one WAIT cycle, with no special case.

Optional Feature:
- Macro MEM_ARB_FAIR_EN.
- With it: a starvation counter (clog2(STARVE_MAX+1) bits) increments on each DM grant made while IF_REQ=1.
  - It clears on any IF grant, or on a DM grant with IF_REQ=0.
  - When it equals STARVE_MAX and both requesters are pending (FLUSH=0), IF wins.
- Without it: strict DM priority, no counter logic present, and IF may starve indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {ST_IDLE, ST_ISSUE, ST_WAIT};
  - owner enum {OWN_IF, OWN_DM};
  - default width constants ADDR_W_DEF=32, DATA_W_DEF=32.
- No sub-module: counter, arbiter and capture are small enough to keep inline in one module.

Test Plan:
1. MEM_LAT=2, IF_REQ at cycle 0 with IF_ADDR=0x40; memory returns 0x2402000A in cycle 3 -> MEM_EN only in cycle 1, IF_ACK in cycle 4, IF_RDATA=0x2402000A, BUSY cycles 1-3.
2. IF_REQ and DM_REQ (write, 0x100, 0xDEADBEEF) both at cycle 0 -> MEM_EN+MEM_WE in cycle 1 with 0x100/0xDEADBEEF, DM_ACK in cycle 2; IF issued in cycle 3, IF_ACK in cycle 6.
3. IF read in flight, FLUSH pulsed in cycle 2 -> IF_ACK never asserted, IF_RDATA unchanged, state IDLE in cycle 4; a DM read at 0x200 then completes normally.
4. RESET asserted in cycle 2 of an IF read -> cycle 3 all outputs 0 and BUSY 0, no IF_ACK; re-request completes with correct data.
5. ENABLE=0 with IF_REQ held for 5 cycles -> no MEM_EN; ENABLE raised in cycle 5 -> MEM_EN in cycle 6.
6. STARVE_MAX=2, DM and IF reads held continuously -> with MEM_ARB_FAIR_EN grant order is DM, DM, IF, DM, DM, IF; without it, 10 consecutive DM grants and no IF_ACK.
